// File: rtl/mlx90640_frame_writer.sv
// Merges one MLX90640 RAM dump (768 pixels + aux words) into a dual-port frame RAM.
// Only the pixels of the active subpage are written; aux words land after the pixel region.
module mlx90640_frame_writer #(
    parameter bit P_CHESS     = 1'b1,
    parameter int P_COLS      = 32,
    parameter int P_ROWS      = 24,
    parameter int P_AUX_WORDS = 64,
    parameter int P_AW        = 10
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_frame_start,
    input  logic            i_subpage,
    input  logic [15:0]     i_data,
    input  logic            i_valid,
    output logic            o_ready,
    output logic            o_we,
    output logic [P_AW-1:0] o_waddr,
    output logic [15:0]     o_wdata,
    output logic            o_busy,
    output logic            o_frame_done,
    output logic            o_done_subpage,
    output logic            o_abort
);

    localparam int N_PIX = P_COLS * P_ROWS;
    localparam int CB    = $clog2(P_COLS);
    localparam logic [P_AW-1:0] LAST_PIX = P_AW'(N_PIX - 1);
    localparam logic [P_AW-1:0] LAST_AUX = P_AW'(N_PIX + P_AUX_WORDS - 1);

    typedef enum logic [1:0] {S_IDLE, S_PIX, S_AUX, S_DONE} state_e;

    state_e          state_q, state_d;
    logic [P_AW-1:0] cnt_q, cnt_d;
    logic            sp_q, sp_d;
    logic            we_q, we_d;
    logic [P_AW-1:0] waddr_q, waddr_d;
    logic [15:0]     wdata_q, wdata_d;
    logic            abort_q, abort_d;
    logic            done_sp_q, done_sp_d;

    logic accept;
    logic sel;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sp_d      = sp_q;
        we_d      = 1'b0;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        abort_d   = 1'b0;
        done_sp_d = done_sp_q;

        o_ready = ((state_q == S_PIX) || (state_q == S_AUX)) && !i_frame_start;
        accept  = i_valid && o_ready;
        sel     = P_CHESS ? ((cnt_q[CB] ^ cnt_q[0]) == sp_q) : (cnt_q[CB] == sp_q);

        unique case (state_q)
            S_IDLE: begin
                if (i_frame_start) begin
                    state_d = S_PIX;
                    cnt_d   = '0;
                    sp_d    = i_subpage;
                end
            end
            S_PIX, S_AUX: begin
                if (i_frame_start) begin
                    // Restart: the partial dump is abandoned without a done pulse.
                    abort_d = 1'b1;
                    state_d = S_PIX;
                    cnt_d   = '0;
                    sp_d    = i_subpage;
                end else if (accept) begin
                    we_d    = (state_q == S_AUX) || sel;
                    waddr_d = cnt_q;
                    wdata_d = i_data;
                    cnt_d   = cnt_q + 1'b1;
                    if (state_q == S_PIX && cnt_q == LAST_PIX) begin
                        if (P_AUX_WORDS > 0) begin
                            state_d = S_AUX;
                        end else begin
                            state_d   = S_DONE;
                            done_sp_d = sp_q;
                        end
                    end else if (state_q == S_AUX && cnt_q == LAST_AUX) begin
                        state_d   = S_DONE;
                        done_sp_d = sp_q;
                    end
                end
            end
            S_DONE: begin
                cnt_d = '0;
                if (i_frame_start) begin
                    state_d = S_PIX;
                    sp_d    = i_subpage;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            sp_q      <= 1'b0;
            we_q      <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            abort_q   <= 1'b0;
            done_sp_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sp_q      <= sp_d;
            we_q      <= we_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            abort_q   <= abort_d;
            done_sp_q <= done_sp_d;
        end
    end

    assign o_we           = we_q;
    assign o_waddr        = waddr_q;
    assign o_wdata        = wdata_q;
    assign o_abort        = abort_q;
    assign o_done_subpage = done_sp_q;
    assign o_busy         = (state_q != S_IDLE);
    assign o_frame_done   = (state_q == S_DONE);

endmodule

// File: tb/tb_mlx90640_frame_writer.sv
// Directed bench for mlx90640_frame_writer: chess and interleaved instances share one stimulus.
module tb_mlx90640_frame_writer;

    localparam int NPIX = 768;
    localparam int NTOT = 832;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, fs, sp_in, v;
    logic [15:0] d;

    logic       c_ready, c_we, c_busy, c_done, c_dsp, c_abort;
    logic [9:0] c_waddr;
    logic [15:0] c_wdata;
    logic       i_ready, i_we, i_busy, i_done, i_dsp, i_abort;
    logic [9:0] i_waddr;
    logic [15:0] i_wdata;

    mlx90640_frame_writer #(.P_CHESS(1'b1)) u_chess (
        .i_clk(clk), .i_rst(rst), .i_frame_start(fs), .i_subpage(sp_in),
        .i_data(d), .i_valid(v), .o_ready(c_ready), .o_we(c_we),
        .o_waddr(c_waddr), .o_wdata(c_wdata), .o_busy(c_busy),
        .o_frame_done(c_done), .o_done_subpage(c_dsp), .o_abort(c_abort)
    );

    mlx90640_frame_writer #(.P_CHESS(1'b0)) u_inter (
        .i_clk(clk), .i_rst(rst), .i_frame_start(fs), .i_subpage(sp_in),
        .i_data(d), .i_valid(v), .o_ready(i_ready), .o_we(i_we),
        .o_waddr(i_waddr), .o_wdata(i_wdata), .o_busy(i_busy),
        .o_frame_done(i_done), .o_done_subpage(i_dsp), .o_abort(i_abort)
    );

    typedef enum {M_IDLE, M_PIX, M_AUX, M_DONE} mstate_e;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    mstate_e     bs = M_IDLE;
    int          idx = 0;
    logic        msp = 1'b0;
    logic        e_dsp = 1'b0;
    logic        e_abort = 1'b0;
    int          e_addr = 0;
    logic [15:0] e_data = '0;

    logic [15:0] ram_c [0:1023];
    logic [9:0]  wq_c[$];
    logic [9:0]  wq_i[$];
    logic [9:0]  t1q[$];
    int          n_done = 0;
    int          n_abort = 0;
    int          bad;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, check o_ready mid-cycle, advance the reference, check registered outputs.
    task automatic cyc(input logic f, input logic s, input logic vv, input logic [15:0] dd, input logic r);
        logic rdy, acc, we_c, we_i;
        rst = r; fs = f; sp_in = s; v = vv; d = dd;
        rdy = (bs == M_PIX || bs == M_AUX) && !f;
        @(negedge clk);
        if (!r) begin
            chk("ready_c", c_ready, rdy);
            chk("ready_i", i_ready, rdy);
        end
        acc = vv && rdy;
        we_c = 1'b0; we_i = 1'b0; e_abort = 1'b0;
        if (r) begin
            bs = M_IDLE; idx = 0; msp = 1'b0; e_dsp = 1'b0;
        end else begin
            if (acc) begin
                we_c   = (idx >= NPIX) || ((((idx >> 5) ^ idx) & 1) == int'(msp));
                we_i   = (idx >= NPIX) || (((idx >> 5) & 1) == int'(msp));
                e_addr = idx;
                e_data = dd;
            end
            case (bs)
                M_IDLE: if (f) begin bs = M_PIX; idx = 0; msp = s; end
                M_PIX, M_AUX: begin
                    if (f) begin
                        e_abort = 1'b1; bs = M_PIX; idx = 0; msp = s;
                    end else if (acc) begin
                        if (idx == NPIX - 1) bs = M_AUX;
                        else if (idx == NTOT - 1) begin bs = M_DONE; e_dsp = msp; end
                        idx++;
                    end
                end
                M_DONE: if (f) begin bs = M_PIX; idx = 0; msp = s; end else bs = M_IDLE;
                default: bs = M_IDLE;
            endcase
        end
        @(posedge clk);
        #1;
        chk("we_c", c_we, we_c);
        chk("we_i", i_we, we_i);
        if (we_c) begin
            chk("waddr_c", c_waddr, e_addr);
            chk("wdata_c", c_wdata, e_data);
        end
        if (we_i) chk("waddr_i", i_waddr, e_addr);
        chk("done_c", c_done, bs == M_DONE);
        chk("done_i", i_done, bs == M_DONE);
        chk("abort", c_abort, e_abort);
        chk("busy", c_busy, bs != M_IDLE);
        chk("dsp", c_dsp, e_dsp);
        if (c_we) begin
            ram_c[c_waddr] = c_wdata;
            wq_c.push_back(c_waddr);
        end
        if (i_we) wq_i.push_back(i_waddr);
        if (c_done) n_done++;
        if (c_abort) n_abort++;
    endtask

    task automatic beats(input int first, input int n, input int gap);
        for (int k = first; k < first + n; k++) begin
            if (gap > 0 && $urandom_range(0, 99) < gap) cyc(1'b0, 1'b0, 1'b0, 16'hbeef, 1'b0);
            cyc(1'b0, 1'b0, 1'b1, 16'(k), 1'b0);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    endtask

    task automatic clear_stats();
        wq_c.delete();
        wq_i.delete();
        n_done = 0;
        n_abort = 0;
    endtask

    initial begin
        rst = 1'b1; fs = 1'b0; sp_in = 1'b0; v = 1'b0; d = '0;
        for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 1'b1, 16'h0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 16'h1111, 1'b0);
        chk("rst_ready", c_ready, 1'b0);

        // T1: chess, subpage 0, data = index
        clear_stats();
        cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        beats(0, NTOT, 0);
        idle(2);
        chk("t1_nwr", wq_c.size(), 448);
        chk("t1_a0", wq_c[0], 0);
        chk("t1_a1", wq_c[1], 2);
        chk("t1_a15", wq_c[15], 30);
        chk("t1_a16", wq_c[16], 33);
        chk("t1_aux0", wq_c[384], 768);
        chk("t1_auxl", wq_c[447], 831);
        chk("t1_ndone", n_done, 1);
        chk("t1_dsp", c_dsp, 1'b0);
        chk("t1_inter_a32", wq_i[32], 64);
        t1q = wq_c;

        // T2 + T3: subpage 1 fills the other chess half; interleaved hits odd rows
        clear_stats();
        cyc(1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
        beats(0, NTOT, 0);
        idle(2);
        bad = 0;
        for (int a = 0; a < NTOT; a++) if (ram_c[a] !== 16'(a)) bad++;
        chk("t2_ram_full", bad, 0);
        bad = 0;
        foreach (wq_c[k]) if (wq_c[k] < NPIX && (((wq_c[k] >> 5) ^ wq_c[k]) & 1) != 1) bad++;
        chk("t2_parity", bad, 0);
        chk("t2_a0", wq_c[0], 1);
        chk("t2_a16", wq_c[16], 32);
        chk("t2_dsp", c_dsp, 1'b1);
        chk("t3_nwr", wq_i.size(), 448);
        chk("t3_a0", wq_i[0], 32);
        chk("t3_a31", wq_i[31], 63);
        chk("t3_a32", wq_i[32], 96);
        chk("t3_a383", wq_i[383], 767);

        // T4: ~50% valid gaps, same write sequence as T1
        clear_stats();
        cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        beats(0, NTOT, 50);
        idle(2);
        chk("t4_nwr", wq_c.size(), t1q.size());
        bad = 0;
        foreach (t1q[k]) if (k < wq_c.size() && wq_c[k] !== t1q[k]) bad++;
        chk("t4_seq", bad, 0);
        chk("t4_ndone", n_done, 1);

        // T5: restart at beat 100 with the other subpage
        clear_stats();
        cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        beats(0, 100, 0);
        cyc(1'b1, 1'b1, 1'b1, 16'hffff, 1'b0);
        beats(0, NTOT, 0);
        idle(2);
        chk("t5_nabort", n_abort, 1);
        chk("t5_ndone", n_done, 1);
        chk("t5_nwr", wq_c.size(), 50 + 448);
        chk("t5_first_new", wq_c[50], 1);
        chk("t5_dsp", c_dsp, 1'b1);

        // T6: reset at beat 500, then a clean dump
        cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        beats(0, 500, 0);
        cyc(1'b0, 1'b0, 1'b1, 16'h1234, 1'b1);
        chk("t6_we", c_we, 1'b0);
        chk("t6_busy", c_busy, 1'b0);
        chk("t6_done", c_done, 1'b0);
        chk("t6_abort", c_abort, 1'b0);
        chk("t6_dsp", c_dsp, 1'b0);
        chk("t6_waddr", c_waddr, 0);
        for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 1'b1, 16'h5555, 1'b0);
        chk("t6_ready", c_ready, 1'b0);
        clear_stats();
        cyc(1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
        beats(0, NTOT, 0);
        idle(2);
        chk("t6_ndone", n_done, 1);
        chk("t6_nwr", wq_c.size(), 448);
        chk("t6_dsp_end", c_dsp, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
